bit_16_restoring_divider: RTL and testbench
===========================================

Name: bit_16_restoring_divider

Overview:
- Multi-cycle 16-bit unsigned integer divider built on repeated trial subtraction. Subtraction is the inverse of the lookahead adder's addition.
- Sits beside the 16-bit adder blocks in the ALU datapath.
- Takes one operand pair per start pulse and returns quotient and remainder after a fixed number of cycles, using a start/busy/done handshake.

Parameters:
- WIDTH, 16, operand/result width in bits; also the number of iteration cycles.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request pulse; sampled on a rising clk edge only when the block is not busy
- dividend  input  WIDTH  unsigned dividend; sampled with start
- divisor  input  WIDTH  unsigned divisor; sampled with start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse; results are valid
- quotient  output  WIDTH  unsigned quotient
- remainder  output  WIDTH  unsigned remainder
- div_by_zero  output  1  set with done when the sampled divisor was 0

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (rst_n).
- Reset (rst_n=0, any time, including mid-operation):
  - state goes to IDLE immediately;
  - busy=0, done=0, div_by_zero=0;
  - quotient=0, remainder=0;
  - iteration counter=0; the in-flight operation is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge latches dividend into the working quotient register Q and divisor into D.
  - Partial remainder R (WIDTH+1 bits) is cleared and the counter is loaded with WIDTH.
  - If divisor != 0: go to RUN, busy=1.
  - If divisor == 0: go directly to DONE, with quotient=all ones (16'hFFFF), remainder=dividend, div_by_zero=1.
- RUN, each edge:
  - shift {R,Q} left by 1;
  - compute trial = R_shifted - {1'b0,D} at WIDTH+1 bits;
  - if trial MSB=0, R=trial and Q[0]=1; else R is kept and Q[0]=0;
  - decrement the counter.
  - When the counter reaches 0 (after exactly WIDTH iterations): go to DONE, quotient=Q, remainder=R[WIDTH-1:0], div_by_zero=0.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - Returns to IDLE on the next edge, unless start=1 at that edge, in which case it behaves exactly as IDLE+start (back-to-back operations allowed).
- Latency, with start sampled at edge E0:
  - nonzero divisor: busy=1 after E0, iterations on E1..E16, done=1 in the cycle after E16 (a 17-cycle start-to-done window);
  - zero divisor: done=1 in the cycle after E0.
- Result holding: quotient, remainder and div_by_zero hold their last values after done until the next operation completes. They are not cleared on a new start.
- start while busy (RUN) is ignored; operands are not resampled.
- Operand changes after the start edge have no effect.
- Invariant for divisor != 0: dividend == quotient*divisor + remainder, and remainder < divisor.

Test Plan:
- Basic divide: dividend=100, divisor=7, start pulse → done exactly 17 cycles after the start edge; quotient=14, remainder=2, div_by_zero=0; busy=1 for 16 cycles.
- Extremes: 16'hFFFF/1 → quotient=16'hFFFF, remainder=0. 16'hFFFF/16'hFFFF → quotient=1, remainder=0. 3/10 → quotient=0, remainder=3.
- Divide by zero: dividend=5, divisor=0 → done one cycle after start; quotient=16'hFFFF, remainder=5, div_by_zero=1. A following 9/3 → quotient=3, remainder=0, div_by_zero=0.
- Busy protection and operand stability:
  - start 1000/10, then pulse start with 7/2 at iteration 5 → ignored; result quotient=100, remainder=0.
  - change the dividend/divisor inputs mid-run → result unchanged.
- Reset mid-operation: start 500/3, assert rst_n=0 asynchronously (between edges) at iteration 8 → busy, done, quotient and remainder go to 0 immediately. After release, start 500/3 → quotient=166, remainder=2.
- Back-to-back plus random check: assert start in the DONE cycle with new operands → accepted with no idle gap. Then run 1000 random nonzero-divisor pairs checked against the invariant.

Source files
------------

// File: rtl/bit_16_restoring_divider_if.sv
// Handshake and operand/result bundle for the restoring divider.
// The master drives operands and start; the slave (divider) returns status and results.
interface bit_16_restoring_divider_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/bit_16_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock via trial subtraction,
// start/busy/done handshake, results held until the next operation completes.
module bit_16_restoring_divider #(
  parameter int WIDTH = 16
) (
  input logic                      clk,
  input logic                      rst_n,
  bit_16_restoring_divider_if.slave div_bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH:0]   r_reg;
  logic [CW-1:0]    count;

  logic [WIDTH+1:0] r_shift;
  logic [WIDTH+1:0] trial;
  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] q_next;
  logic             accept;

  // One extra guard bit on the trial so its sign bit reflects the full shifted remainder.
  always_comb begin
    r_shift = {r_reg, q_reg[WIDTH-1]};
    trial   = r_shift - {2'b00, d_reg};
    r_next  = trial[WIDTH+1] ? r_shift[WIDTH:0] : trial[WIDTH:0];
    q_next  = {q_reg[WIDTH-2:0], ~trial[WIDTH+1]};
    accept  = div_bus.start && (state != RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      q_reg               <= '0;
      d_reg               <= '0;
      r_reg               <= '0;
      count               <= '0;
      div_bus.busy        <= 1'b0;
      div_bus.done        <= 1'b0;
      div_bus.quotient    <= '0;
      div_bus.remainder   <= '0;
      div_bus.div_by_zero <= 1'b0;
    end else begin
      div_bus.done <= 1'b0;
      if (accept) begin
        q_reg <= div_bus.dividend;
        d_reg <= div_bus.divisor;
        r_reg <= '0;
        count <= CW'(WIDTH);
        if (div_bus.divisor != '0) begin
          state        <= RUN;
          div_bus.busy <= 1'b1;
        end else begin
          state               <= DONE;
          div_bus.busy        <= 1'b0;
          div_bus.done        <= 1'b1;
          div_bus.quotient    <= '1;
          div_bus.remainder   <= div_bus.dividend;
          div_bus.div_by_zero <= 1'b1;
        end
      end else begin
        case (state)
          RUN: begin
            q_reg <= q_next;
            r_reg <= r_next;
            count <= count - CW'(1);
            // Last iteration: publish the freshly computed bits, not the stale registers.
            if (count == CW'(1)) begin
              state               <= DONE;
              div_bus.busy        <= 1'b0;
              div_bus.done        <= 1'b1;
              div_bus.quotient    <= q_next;
              div_bus.remainder   <= r_next[WIDTH-1:0];
              div_bus.div_by_zero <= 1'b0;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_bit_16_restoring_divider.sv
// Scoreboard-driven bench for the restoring divider: expected results are queued at start
// and compared when done pulses.
module tb_bit_16_restoring_divider;
  logic clk;
  logic rst_n;

  bit_16_restoring_divider_if #(.WIDTH(16)) bus ();

  bit_16_restoring_divider #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .div_bus (bus.slave)
  );

  typedef struct packed {
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
  } result_t;

  result_t sb[$];
  int      checks;
  int      fails;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one start pulse; when now=1 the caller is already at a falling edge.
  task automatic issue(input logic [15:0] dd, input logic [15:0] dv, input bit now);
    result_t e;
    if (!now) @(negedge clk);
    bus.dividend = dd;
    bus.divisor  = dv;
    bus.start    = 1'b1;
    e.q   = (dv == 16'd0) ? 16'hFFFF : dd / dv;
    e.r   = (dv == 16'd0) ? dd : dd % dv;
    e.dbz = (dv == 16'd0);
    sb.push_back(e);
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(output int cycles, output int busy_cycles);
    cycles      = 0;
    busy_cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (bus.busy === 1'b1) busy_cycles++;
    end while (bus.done !== 1'b1 && cycles < 40);
    checks++;
    if (bus.done !== 1'b1) begin
      fails++;
      $display("[TB] FAIL done_timeout: done=%b after %0d cycles, required 1", bus.done, cycles);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    #12;
    checks++;
    if ({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder} !== 35'd0) begin
      fails++;
      $display("[TB] FAIL reset_state: got busy=%b done=%b dbz=%b q=%h r=%h, required all 0",
               bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int cyc, bcyc;
    result_t e;
    issue(16'd100, 16'd7, 1'b0);
    wait_done(cyc, bcyc);
    e = sb.pop_front();
    checks++;
    if (cyc != 17 || bcyc != 16) begin
      fails++;
      $display("[TB] FAIL basic_latency: done after %0d cycles busy %0d, required 17 and 16", cyc, bcyc);
    end
    checks++;
    if ({bus.quotient, bus.remainder, bus.div_by_zero} !== e || e.q !== 16'd14 || e.r !== 16'd2) begin
      fails++;
      $display("[TB] FAIL basic_result: got q=%0d r=%0d dbz=%b, required q=14 r=2 dbz=0",
               bus.quotient, bus.remainder, bus.div_by_zero);
    end
  endtask

  task automatic test_extremes();
    logic [15:0] dds [3];
    logic [15:0] dvs [3];
    int cyc, bcyc;
    result_t e;
    dds = '{16'hFFFF, 16'hFFFF, 16'd3};
    dvs = '{16'd1, 16'hFFFF, 16'd10};
    for (int i = 0; i < 3; i++) begin
      issue(dds[i], dvs[i], 1'b0);
      wait_done(cyc, bcyc);
      e = sb.pop_front();
      checks++;
      if ({bus.quotient, bus.remainder, bus.div_by_zero} !== e) begin
        fails++;
        $display("[TB] FAIL extreme_%0d: got q=%h r=%h dbz=%b, required q=%h r=%h dbz=%b",
                 i, bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r, e.dbz);
      end
    end
  endtask

  task automatic test_div_by_zero();
    int cyc, bcyc;
    result_t e;
    issue(16'd5, 16'd0, 1'b0);
    wait_done(cyc, bcyc);
    e = sb.pop_front();
    checks++;
    if (cyc != 1 || {bus.quotient, bus.remainder, bus.div_by_zero} !== {16'hFFFF, 16'd5, 1'b1}) begin
      fails++;
      $display("[TB] FAIL div_zero: got cyc=%0d q=%h r=%0d dbz=%b, required cyc=1 q=ffff r=5 dbz=1",
               cyc, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    issue(16'd9, 16'd3, 1'b0);
    wait_done(cyc, bcyc);
    e = sb.pop_front();
    checks++;
    if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {16'd3, 16'd0, 1'b0}) begin
      fails++;
      $display("[TB] FAIL after_zero: got q=%0d r=%0d dbz=%b, required q=3 r=0 dbz=0",
               bus.quotient, bus.remainder, bus.div_by_zero);
    end
  endtask

  task automatic test_busy_protect();
    int cyc, bcyc;
    result_t e;
    issue(16'd1000, 16'd10, 1'b0);
    repeat (5) @(negedge clk);
    bus.dividend = 16'd7;
    bus.divisor  = 16'd2;
    bus.start    = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(cyc, bcyc);
    e = sb.pop_front();
    checks++;
    if (cyc + 5 != 17 || {bus.quotient, bus.remainder, bus.div_by_zero} !== e) begin
      fails++;
      $display("[TB] FAIL busy_ignore: got cyc=%0d q=%0d r=%0d, required cyc=17 q=%0d r=%0d",
               cyc + 5, bus.quotient, bus.remainder, e.q, e.r);
    end
  endtask

  task automatic test_operand_change();
    int cyc, bcyc;
    result_t e;
    issue(16'd1000, 16'd10, 1'b0);
    repeat (3) @(negedge clk);
    bus.dividend = 16'd123;
    bus.divisor  = 16'd0;
    wait_done(cyc, bcyc);
    e = sb.pop_front();
    checks++;
    if ({bus.quotient, bus.remainder, bus.div_by_zero} !== e) begin
      fails++;
      $display("[TB] FAIL operand_stable: got q=%0d r=%0d dbz=%b, required q=%0d r=%0d dbz=0",
               bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r);
    end
  endtask

  task automatic test_reset_mid_op();
    int cyc, bcyc;
    result_t e;
    issue(16'd500, 16'd3, 1'b0);
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.quotient, bus.remainder} !== 34'd0) begin
      fails++;
      $display("[TB] FAIL async_reset: got busy=%b done=%b q=%h r=%h, required all 0",
               bus.busy, bus.done, bus.quotient, bus.remainder);
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    issue(16'd500, 16'd3, 1'b0);
    wait_done(cyc, bcyc);
    e = sb.pop_front();
    checks++;
    if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {16'd166, 16'd2, 1'b0}) begin
      fails++;
      $display("[TB] FAIL post_reset: got q=%0d r=%0d dbz=%b, required q=166 r=2 dbz=0",
               bus.quotient, bus.remainder, bus.div_by_zero);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, bcyc;
    result_t e;
    issue(16'd100, 16'd7, 1'b0);
    wait_done(cyc, bcyc);
    e = sb.pop_front();
    checks++;
    if ({bus.quotient, bus.remainder, bus.div_by_zero} !== e) begin
      fails++;
      $display("[TB] FAIL b2b_first: got q=%0d r=%0d, required q=%0d r=%0d",
               bus.quotient, bus.remainder, e.q, e.r);
    end
    issue(16'd60000, 16'd300, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL b2b_accept: got busy=%b, required 1", bus.busy);
    end
    wait_done(cyc, bcyc);
    e = sb.pop_front();
    checks++;
    if (cyc + 1 != 17 || {bus.quotient, bus.remainder, bus.div_by_zero} !== e) begin
      fails++;
      $display("[TB] FAIL b2b_second: got cyc=%0d q=%0d r=%0d, required cyc=17 q=%0d r=%0d",
               cyc + 1, bus.quotient, bus.remainder, e.q, e.r);
    end
  endtask

  task automatic test_random();
    int cyc, bcyc;
    result_t e;
    logic [15:0] dd, dv;
    for (int i = 0; i < 1000; i++) begin
      dd = 16'($urandom_range(0, 65535));
      dv = (i % 2 == 1) ? 16'($urandom_range(1, 255)) : 16'($urandom_range(1, 65535));
      issue(dd, dv, 1'b0);
      wait_done(cyc, bcyc);
      e = sb.pop_front();
      checks++;
      if ({bus.quotient, bus.remainder, bus.div_by_zero} !== e) begin
        fails++;
        $display("[TB] FAIL random_%0d: %0d/%0d got q=%0d r=%0d, required q=%0d r=%0d",
                 i, dd, dv, bus.quotient, bus.remainder, e.q, e.r);
      end
      checks++;
      if ({16'd0, dd} !== 32'(bus.quotient) * 32'(dv) + 32'(bus.remainder) || bus.remainder >= dv) begin
        fails++;
        $display("[TB] FAIL invariant_%0d: %0d/%0d got q=%0d r=%0d, required q*d+r=dividend and r<d",
                 i, dd, dv, bus.quotient, bus.remainder);
      end
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_basic();
    test_extremes();
    test_div_by_zero();
    test_busy_protect();
    test_operand_change();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
